// File: rtl/char_pair_feeder.sv
// Host-side word FIFO that hands one (primary, secondary) character pair per
// request to the traversal engine, with length tracking and stall/overrun status.
module char_pair_feeder #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_word,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             input_char_flag,
    output logic [7:0]       input_char,
    output logic [7:0]       input_char_2,
    output logic             char_valid,
    input  logic [CNT_W-1:0] total_chars,
    output logic [CNT_W-1:0] chars_sent,
    output logic             stream_done,
    output logic [15:0]      stall_cycles,
    output logic             req_overrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             half;
    logic             pend;

    logic             push;
    logic             pop;
    logic             want;
    logic             serve;
    logic             stall;
    logic             overrun;
    logic [31:0]      head;
    logic [7:0]       lane_a;
    logic [7:0]       lane_b;
    logic [CNT_W-1:0] sent_next;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_ready  = (count != FULL);
    assign push      = in_valid & in_ready;
    assign want      = pend | input_char_flag;
    assign serve     = want & (count != '0) & ~stream_done;
    assign stall     = want & (count == '0) & ~stream_done;
    // A second request while one is still waiting is dropped, not queued.
    assign overrun   = input_char_flag & pend & ~serve & ~stream_done;
    assign pop       = serve & half;
    assign sent_next = chars_sent + CNT_W'(1);

    assign head   = mem[rd_ptr];
    assign lane_a = half ? head[23:16] : head[7:0];
    assign lane_b = half ? head[31:24] : head[15:8];

    // Storage array carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            half <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (serve) begin
                half <= ~half;
            end
            if (serve || stream_done) begin
                pend <= 1'b0;
            end else if (input_char_flag) begin
                pend <= 1'b1;
            end
        end
    end

    // Output stage: pair registers hold their value between serves.
    always_ff @(posedge clk) begin
        if (!reset) begin
            input_char   <= 8'h00;
            input_char_2 <= 8'h00;
            char_valid   <= 1'b0;
            chars_sent   <= '0;
            stream_done  <= 1'b0;
        end else begin
            char_valid <= serve;
            if (serve) begin
                input_char   <= lane_a;
                input_char_2 <= lane_b;
                chars_sent   <= sent_next;
                if ((sent_next == total_chars) && (total_chars != '0)) begin
                    stream_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= 16'h0000;
            req_overrun  <= 1'b0;
        end else begin
            if (stall) begin
                stall_cycles <= sat_inc16(stall_cycles);
            end
            if (overrun) begin
                req_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_char_pair_feeder.sv
// Scoreboard bench for char_pair_feeder: expected pairs and their delivery
// cycle are queued as requests are driven and matched against char_valid.
module tb_char_pair_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        input_char_flag;
    logic [7:0]  input_char;
    logic [7:0]  input_char_2;
    logic        char_valid;
    logic [23:0] total_chars;
    logic [23:0] chars_sent;
    logic        stream_done;
    logic [15:0] stall_cycles;
    logic        req_overrun;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    char_pair_feeder #(.DEPTH(16), .CNT_W(24)) dut (
        .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .input_char_flag(input_char_flag),
        .input_char(input_char), .input_char_2(input_char_2),
        .char_valid(char_valid), .total_chars(total_chars),
        .chars_sent(chars_sent), .stream_done(stream_done),
        .stall_cycles(stall_cycles), .req_overrun(req_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every char_valid must match the queue head at its expected cycle.
    always @(negedge clk) begin
        if (char_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(char_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lane_a", 32'(input_char), 32'(e.a));
                chk("lane_b", 32'(input_char_2), 32'(e.b));
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            chk("missed_valid", 32'(cyc), 32'(sb[0].cyc));
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pair(input logic [7:0] a, input logic [7:0] b, input int c);
        exp_t e;
        e.a = a;
        e.b = b;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_char_valid"}, 32'(char_valid), 32'd0);
        chk({tag, "_input_char"}, 32'(input_char), 32'd0);
        chk({tag, "_input_char_2"}, 32'(input_char_2), 32'd0);
        chk({tag, "_chars_sent"}, 32'(chars_sent), 32'd0);
        chk({tag, "_stream_done"}, 32'(stream_done), 32'd0);
        chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
        chk({tag, "_overrun"}, 32'(req_overrun), 32'd0);
    endtask

    task automatic do_reset(input logic [23:0] total);
        reset = 1'b0;
        in_valid = 1'b0;
        in_word = 32'h0;
        input_char_flag = 1'b0;
        total_chars = total;
        tick();
        tick();
        reset = 1'b1;
        check_reset_state("rst");
        tick();
    endtask

    task automatic write_word(input logic [31:0] w);
        int n = 0;
        in_word = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("write_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic req(input bit served, input logic [7:0] a, input logic [7:0] b);
        input_char_flag = 1'b1;
        if (served) expect_pair(a, b, cyc + 1);
        tick();
        input_char_flag = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Basic delivery
        do_reset(24'd2);
        write_word(32'h44332211);
        tick();
        input_char_flag = 1'b1;
        expect_pair(8'h11, 8'h22, cyc + 1);
        tick();
        input_char_flag = 1'b0;
        @(negedge clk);
        chk("basic_sent1", 32'(chars_sent), 32'd1);
        chk("basic_done_early", 32'(stream_done), 32'd0);
        tick();
        input_char_flag = 1'b1;
        expect_pair(8'h33, 8'h44, cyc + 1);
        tick();
        input_char_flag = 1'b0;
        @(negedge clk);
        chk("basic_done", 32'(stream_done), 32'd1);
        chk("basic_sent2", 32'(chars_sent), 32'd2);
        wait_drain();

        // Underflow stall
        do_reset(24'd4);
        input_char_flag = 1'b1;
        tick();
        input_char_flag = 1'b0;
        tick();
        tick();
        tick();
        in_word = 32'hDDCCBBAA;
        in_valid = 1'b1;
        expect_pair(8'hAA, 8'hBB, cyc + 2);
        @(negedge clk);
        chk("stall_at_accept", 32'(stall_cycles), 32'd4);
        tick();
        in_valid = 1'b0;
        wait_drain();
        chk("stall_final", 32'(stall_cycles), 32'd5);
        chk("stall_overrun", 32'(req_overrun), 32'd0);

        // Full FIFO
        do_reset(24'd40);
        for (int i = 0; i < 16; i++) begin
            in_word = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            in_valid = 1'b1;
            chk("fill_ready", 32'(in_ready), 32'd1);
            tick();
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        in_word = 32'hDEADBEEF;
        tick();
        chk("full_hold", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        c = cyc;
        for (int k = 0; k <= 32; k++) begin
            input_char_flag = 1'b1;
            if (k < 32) expect_pair(8'(2*k), 8'(2*k+1), c + k + 1);
            if (k == 1) chk("ready_after_one", 32'(in_ready), 32'd0);
            if (k == 2) chk("ready_after_pop", 32'(in_ready), 32'd1);
            tick();
        end
        input_char_flag = 1'b0;
        @(negedge clk);
        chk("full_sent", 32'(chars_sent), 32'd32);
        chk("full_empty_stall", 32'(stall_cycles), 32'd1);
        wait_drain();

        // Overrun
        do_reset(24'd5);
        input_char_flag = 1'b1;
        tick();
        @(negedge clk);
        chk("overrun_early", 32'(req_overrun), 32'd0);
        tick();
        input_char_flag = 1'b0;
        @(negedge clk);
        chk("overrun_set", 32'(req_overrun), 32'd1);
        tick();
        in_word = 32'h54535251;
        in_valid = 1'b1;
        expect_pair(8'h51, 8'h52, cyc + 2);
        tick();
        in_valid = 1'b0;
        wait_drain();
        repeat (4) tick();
        chk("overrun_one_valid", 32'(chars_sent), 32'd1);
        chk("overrun_sticky", 32'(req_overrun), 32'd1);

        // Odd length and done
        do_reset(24'd3);
        write_word(32'h14131211);
        write_word(32'h24232221);
        req(1'b1, 8'h11, 8'h12);
        req(1'b1, 8'h13, 8'h14);
        req(1'b1, 8'h21, 8'h22);
        req(1'b0, 8'h00, 8'h00);
        req(1'b0, 8'h00, 8'h00);
        wait_drain();
        chk("odd_done", 32'(stream_done), 32'd1);
        chk("odd_sent", 32'(chars_sent), 32'd3);
        chk("odd_overrun", 32'(req_overrun), 32'd0);
        chk("odd_stall", 32'(stall_cycles), 32'd0);
        chk("odd_ready", 32'(in_ready), 32'd1);
        chk("odd_hold_a", 32'(input_char), 32'h21);

        // Reset mid-operation
        do_reset(24'd4);
        write_word(32'h34333231);
        req(1'b1, 8'h31, 8'h32);
        wait_drain();
        reset = 1'b0;
        input_char_flag = 1'b1;
        tick();
        reset = 1'b1;
        input_char_flag = 1'b0;
        check_reset_state("mid");
        tick();
        input_char_flag = 1'b1;
        tick();
        input_char_flag = 1'b0;
        @(negedge clk);
        chk("mid_stall", 32'(stall_cycles), 32'd1);
        repeat (4) tick();
        chk("mid_no_serve", 32'(chars_sent), 32'd0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
